// File: rtl/riscv_trace_buffer.sv
// Snoops fetch/write/read-ack traffic into a circular trace buffer with arm/trigger/post-trigger
// capture and a valid/ready drain port. Define TRACE_FILTER_EN to add address filtering of data events.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | not capturing; buffered entries may be drained
// ARMED | capturing, waiting for the trigger event
// POST  | trigger seen, capturing the remaining post-trigger entries
// DONE  | capture finished; entries may be drained
module riscv_trace_buffer #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int POST_TRIG = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              arm_i,
    input  logic              clear_i,
    input  logic              mode_wrap_i,
    input  logic              trig_en_i,
    input  logic [31:0]       trig_pc_i,
`ifdef TRACE_FILTER_EN
    input  logic [31:0]       filt_base_i,
    input  logic [31:0]       filt_mask_i,
`endif
    input  logic              mem_i_valid_i,
    input  logic [31:0]       mem_i_pc_i,
    input  logic [63:0]       mem_i_inst_i,
    input  logic [31:0]       mem_d_addr_i,
    input  logic [31:0]       mem_d_data_wr_i,
    input  logic [3:0]        mem_d_wr_i,
    input  logic              mem_d_rd_i,
    input  logic              mem_d_accept_i,
    input  logic              mem_d_ack_i,
    input  logic [31:0]       mem_d_data_rd_i,
    input  logic              tr_ready_i,
    output logic              tr_valid_o,
    output logic [1:0]        tr_type_o,
    output logic [31:0]       tr_addr_o,
    output logic [63:0]       tr_data_o,
    output logic [1:0]        state_o,
    output logic [ADDR_W:0]   count_o,
    output logic [15:0]       drop_cnt_o,
    output logic              triggered_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] POST_INIT = ADDR_W'(POST_TRIG - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q, post_cnt_q;
    logic [ADDR_W:0]     count_q;
    logic [15:0]         drop_q;
    logic                triggered_q;
    logic [31:0]         rd_addr_q;

    logic [1:0]          buf_type [DEPTH];
    logic [31:0]         buf_addr [DEPTH];
    logic [63:0]         buf_data [DEPTH];

    logic                wr_raw, wr_pass, rd_pass;
    logic                fetch_ev, wr_ev, rd_ev, any_ev;
    logic                capturing, full, block, do_write, trig_hit, pop, restart;
    logic [1:0]          n_ev, drop_inc;
    logic [16:0]         drop_sum;
    logic [15:0]         drop_next;
    logic [1:0]          ent_type;
    logic [31:0]         ent_addr;
    logic [63:0]         ent_data;

    assign wr_raw = (|mem_d_wr_i) & mem_d_accept_i;

`ifdef TRACE_FILTER_EN
    assign wr_pass = (mem_d_addr_i & filt_mask_i) == (filt_base_i & filt_mask_i);
    assign rd_pass = (rd_addr_q & filt_mask_i) == (filt_base_i & filt_mask_i);
`else
    assign wr_pass = 1'b1;
    assign rd_pass = 1'b1;
`endif

    assign fetch_ev  = mem_i_valid_i;
    assign wr_ev     = wr_raw & wr_pass;
    // A read ack is suppressed by any accepted write, even one the filter rejects.
    assign rd_ev     = mem_d_ack_i & ~wr_raw & rd_pass;
    assign any_ev    = fetch_ev | wr_ev | rd_ev;
    assign n_ev      = {1'b0, fetch_ev} + {1'b0, wr_ev} + {1'b0, rd_ev};

    assign capturing = (state_q == ST_ARMED) | (state_q == ST_POST);
    assign full      = (count_q == FULL_CNT);
    assign block     = capturing & any_ev & (state_q == ST_ARMED) & full & ~mode_wrap_i;
    assign do_write  = capturing & any_ev & ~block;
    assign trig_hit  = (state_q == ST_ARMED) & do_write &
                       (~trig_en_i | (fetch_ev & (mem_i_pc_i == trig_pc_i)));
    assign pop       = tr_valid_o & tr_ready_i;
    assign restart   = arm_i & ((state_q == ST_IDLE) | (state_q == ST_DONE));

    assign drop_inc  = (capturing & any_ev) ? (n_ev - 2'd1) + {1'b0, block} : 2'd0;
    assign drop_sum  = {1'b0, drop_q} + {15'd0, drop_inc};
    assign drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    always_comb begin
        ent_type = 2'd2;
        ent_addr = rd_addr_q;
        ent_data = {32'd0, mem_d_data_rd_i};
        if (fetch_ev) begin
            ent_type = 2'd0;
            ent_addr = mem_i_pc_i;
            ent_data = mem_i_inst_i;
        end else if (wr_ev) begin
            ent_type = 2'd1;
            ent_addr = mem_d_addr_i;
            ent_data = {28'd0, mem_d_wr_i, mem_d_data_wr_i};
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (arm_i) state_d = ST_ARMED;
                ST_ARMED: if (trig_hit) state_d = (POST_TRIG == 1) ? ST_DONE : ST_POST;
                // post_cnt_q counts entries still to capture after the trigger entry
                ST_POST: if (do_write && post_cnt_q == PTR_ONE) state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            drop_q      <= '0;
            triggered_q <= 1'b0;
            post_cnt_q  <= '0;
            rd_addr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (mem_d_rd_i && mem_d_accept_i) rd_addr_q <= mem_d_addr_i;
            if (clear_i || restart) begin
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                count_q     <= '0;
                drop_q      <= '0;
                triggered_q <= 1'b0;
            end else begin
                drop_q <= drop_next;
                if (do_write) begin
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                    if (full) rd_ptr_q <= rd_ptr_q + PTR_ONE;
                    else      count_q  <= count_q + CNT_ONE;
                end else if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                    count_q  <= count_q - CNT_ONE;
                end
                if (trig_hit) begin
                    triggered_q <= 1'b1;
                    post_cnt_q  <= POST_INIT;
                end else if (state_q == ST_POST && do_write) begin
                    post_cnt_q <= post_cnt_q - PTR_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_write && !clear_i) begin
            buf_type[wr_ptr_q] <= ent_type;
            buf_addr[wr_ptr_q] <= ent_addr;
            buf_data[wr_ptr_q] <= ent_data;
        end
    end

    assign tr_valid_o  = (count_q != '0) & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    assign tr_type_o   = buf_type[rd_ptr_q];
    assign tr_addr_o   = buf_addr[rd_ptr_q];
    assign tr_data_o   = buf_data[rd_ptr_q];
    assign state_o     = state_q;
    assign count_o     = count_q;
    assign drop_cnt_o  = drop_q;
    assign triggered_o = triggered_q;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Scoreboard bench for riscv_trace_buffer: a queue-based reference model predicts buffer contents,
// a monitor pops and compares on every drain handshake. Exercises TRACE_FILTER_EN when defined.
module tb_riscv_trace_buffer;
    localparam int DEPTH     = 16;
    localparam int ADDR_W    = 4;
    localparam int POST_TRIG = 8;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic arm_i = 0, clear_i = 0, mode_wrap_i = 0, trig_en_i = 0;
    logic [31:0] trig_pc_i = '0;
`ifdef TRACE_FILTER_EN
    logic [31:0] filt_base_i = 32'h8000_1000;
    logic [31:0] filt_mask_i = 32'hFFFF_F000;
`endif
    logic        mem_i_valid_i = 0;
    logic [31:0] mem_i_pc_i = '0;
    logic [63:0] mem_i_inst_i = '0;
    logic [31:0] mem_d_addr_i = '0, mem_d_data_wr_i = '0, mem_d_data_rd_i = '0;
    logic [3:0]  mem_d_wr_i = '0;
    logic        mem_d_rd_i = 0, mem_d_accept_i = 0, mem_d_ack_i = 0, tr_ready_i = 0;
    logic        tr_valid_o, triggered_o;
    logic [1:0]  tr_type_o, state_o;
    logic [31:0] tr_addr_o;
    logic [63:0] tr_data_o;
    logic [ADDR_W:0] count_o;
    logic [15:0] drop_cnt_o;

    riscv_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .POST_TRIG(POST_TRIG)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .arm_i(arm_i), .clear_i(clear_i),
        .mode_wrap_i(mode_wrap_i), .trig_en_i(trig_en_i), .trig_pc_i(trig_pc_i),
`ifdef TRACE_FILTER_EN
        .filt_base_i(filt_base_i), .filt_mask_i(filt_mask_i),
`endif
        .mem_i_valid_i(mem_i_valid_i), .mem_i_pc_i(mem_i_pc_i), .mem_i_inst_i(mem_i_inst_i),
        .mem_d_addr_i(mem_d_addr_i), .mem_d_data_wr_i(mem_d_data_wr_i), .mem_d_wr_i(mem_d_wr_i),
        .mem_d_rd_i(mem_d_rd_i), .mem_d_accept_i(mem_d_accept_i), .mem_d_ack_i(mem_d_ack_i),
        .mem_d_data_rd_i(mem_d_data_rd_i), .tr_ready_i(tr_ready_i), .tr_valid_o(tr_valid_o),
        .tr_type_o(tr_type_o), .tr_addr_o(tr_addr_o), .tr_data_o(tr_data_o), .state_o(state_o),
        .count_o(count_o), .drop_cnt_o(drop_cnt_o), .triggered_o(triggered_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [1:0]  t;
        logic [31:0] a;
        logic [63:0] d;
    } ent_t;

    ent_t        mdl_q[$];
    int          m_st = 0;
    int          m_drop = 0;
    int          m_post = 0;
    bit          m_trig = 0;
    logic [31:0] m_rd_addr = '0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_drop();
        if (m_drop < 16'hFFFF) m_drop++;
    endtask

    task automatic model_reset();
        mdl_q.delete();
        m_st = 0; m_drop = 0; m_post = 0; m_trig = 0; m_rd_addr = '0;
    endtask

    // Reference behaviour for one clock edge, from the inputs currently driven.
    task automatic model_step();
        ent_t ev[$];
        ent_t e;
        bit   wr_raw, wr_ok, rd_ok, stored;
        wr_raw = (|mem_d_wr_i) && mem_d_accept_i;
        wr_ok = 1; rd_ok = 1; stored = 0;
`ifdef TRACE_FILTER_EN
        wr_ok = (mem_d_addr_i & filt_mask_i) == (filt_base_i & filt_mask_i);
        rd_ok = (m_rd_addr & filt_mask_i) == (filt_base_i & filt_mask_i);
`endif
        if (clear_i) begin
            mdl_q.delete(); m_drop = 0; m_trig = 0; m_st = 0;
        end else if (arm_i && (m_st == 0 || m_st == 3)) begin
            mdl_q.delete(); m_drop = 0; m_trig = 0; m_st = 1;
        end else if (m_st == 1 || m_st == 2) begin
            if (mem_i_valid_i) begin
                e.t = 2'd0; e.a = mem_i_pc_i; e.d = mem_i_inst_i; ev.push_back(e);
            end
            if (wr_raw && wr_ok) begin
                e.t = 2'd1; e.a = mem_d_addr_i; e.d = {28'd0, mem_d_wr_i, mem_d_data_wr_i}; ev.push_back(e);
            end
            if (mem_d_ack_i && !wr_raw && rd_ok) begin
                e.t = 2'd2; e.a = m_rd_addr; e.d = {32'd0, mem_d_data_rd_i}; ev.push_back(e);
            end
            if (ev.size() > 0) begin
                for (int i = 1; i < ev.size(); i++) add_drop();
                e = ev[0];
                if (m_st == 1 && mdl_q.size() == DEPTH && !mode_wrap_i) begin
                    add_drop();
                end else begin
                    if (mdl_q.size() == DEPTH) void'(mdl_q.pop_front());
                    mdl_q.push_back(e);
                    stored = 1;
                end
                if (stored && m_st == 1) begin
                    if (!trig_en_i || (e.t == 2'd0 && e.a == trig_pc_i)) begin
                        m_trig = 1;
                        m_post = POST_TRIG - 1;
                        m_st = (POST_TRIG == 1) ? 3 : 2;
                    end
                end else if (stored) begin
                    m_post--;
                    if (m_post == 0) m_st = 3;
                end
            end
        end
        if (mem_d_rd_i && mem_d_accept_i) m_rd_addr = mem_d_addr_i;
    endtask

    // Monitor: every handshake pops the predicted oldest entry and compares it.
    always @(negedge clk_i) begin
        ent_t e;
        if (rst_i) begin
            chk("tr_valid", {63'd0, tr_valid_o}, {63'd0, (mdl_q.size() != 0) && (m_st == 0 || m_st == 3)});
            if (tr_valid_o && tr_ready_i) begin
                if (mdl_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL pop_empty: got entry %0h expected none", tr_addr_o);
                end else begin
                    e = mdl_q.pop_front();
                    chk("tr_type", {62'd0, tr_type_o}, {62'd0, e.t});
                    chk("tr_addr", {32'd0, tr_addr_o}, {32'd0, e.a});
                    chk("tr_data", tr_data_o, e.d);
                end
            end
        end
    end

    task automatic check_status();
        chk("state", {62'd0, state_o}, 64'(m_st));
        chk("count", {59'd0, count_o}, 64'(mdl_q.size()));
        chk("drop_cnt", {48'd0, drop_cnt_o}, 64'(m_drop));
        chk("triggered", {63'd0, triggered_o}, {63'd0, m_trig});
    endtask

    task automatic tick();
        @(negedge clk_i); #1;
        model_step();
        @(posedge clk_i); #1;
        check_status();
    endtask

    task automatic quiet();
        arm_i = 0; clear_i = 0; mem_i_valid_i = 0; mem_d_wr_i = '0;
        mem_d_rd_i = 0; mem_d_accept_i = 0; mem_d_ack_i = 0;
    endtask

    task automatic pulse_arm();
        quiet(); arm_i = 1; tick(); arm_i = 0;
    endtask

    task automatic pulse_clear();
        quiet(); clear_i = 1; tick(); clear_i = 0;
    endtask

    task automatic fetch(input logic [31:0] pc);
        quiet();
        mem_i_valid_i = 1; mem_i_pc_i = pc; mem_i_inst_i = {$urandom, $urandom};
        tick();
        mem_i_valid_i = 0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        quiet(); tr_ready_i = 1;
        while (mdl_q.size() != 0 && guard < 64) begin
            tick(); guard++;
        end
        if (guard >= 64) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: got %0d entries left expected 0", mdl_q.size());
        end
        tr_ready_i = 0;
    endtask

    task automatic async_reset();
        rst_i = 0; #1;
        model_reset();
        chk("rst_state", {62'd0, state_o}, 64'd0);
        chk("rst_count", {59'd0, count_o}, 64'd0);
        chk("rst_drop", {48'd0, drop_cnt_o}, 64'd0);
        chk("rst_valid", {63'd0, tr_valid_o}, 64'd0);
        chk("rst_trig", {63'd0, triggered_o}, 64'd0);
        #1 rst_i = 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        quiet();
        #23 rst_i = 1;
        @(posedge clk_i); #1;
        check_status();

        // Mid-capture asynchronous reset
        trig_en_i = 0; mode_wrap_i = 1;
        pulse_arm();
        for (int k = 0; k < 3; k++) fetch(32'h8000_0000 + 32'(k * 8));
        async_reset();

        // Immediate trigger, post-trigger window of 8
        pulse_arm();
        for (int k = 0; k < 10; k++) fetch(32'h8000_0000 + 32'(k * 8));
        chk("t2_state", {62'd0, state_o}, 64'd3);
        chk("t2_count", {59'd0, count_o}, 64'd8);
        chk("t2_first", {32'd0, tr_addr_o}, 64'h8000_0000);
        drain();

        // PC trigger with wrap: last 16 entries kept
        trig_en_i = 1; trig_pc_i = 32'h8000_0100; mode_wrap_i = 1;
        pulse_arm();
        for (int k = 0; k < 40; k++) fetch(32'h8000_0000 + 32'(k * 8));
        chk("t3_state", {62'd0, state_o}, 64'd3);
        chk("t3_count", {59'd0, count_o}, 64'd16);
        chk("t3_first", {32'd0, tr_addr_o}, 64'h8000_00C0);
        chk("t3_drop", {48'd0, drop_cnt_o}, 64'd0);
        drain();

        // No wrap, never triggered: stops at full, counts drops
        mode_wrap_i = 0; trig_pc_i = 32'hFFFF_FFF0;
        pulse_arm();
        for (int k = 0; k < 20; k++) fetch(32'h8000_0000 + 32'(k * 4));
        chk("t5_count", {59'd0, count_o}, 64'd16);
        chk("t5_drop", {48'd0, drop_cnt_o}, 64'd4);
        chk("t5_state", {62'd0, state_o}, 64'd1);
        pulse_clear();
        chk("t5_clr_count", {59'd0, count_o}, 64'd0);
        chk("t5_clr_state", {62'd0, state_o}, 64'd0);

        // Fetch beats write; latched read address used on ack
        mode_wrap_i = 1;
        pulse_arm();
        quiet();
        mem_i_valid_i = 1; mem_i_pc_i = 32'h8000_0400; mem_i_inst_i = 64'h1111_2222_3333_4444;
        mem_d_addr_i = 32'h8000_1000; mem_d_wr_i = 4'hF; mem_d_accept_i = 1; mem_d_data_wr_i = 32'h55AA_55AA;
        tick();
        chk("t4_drop", {48'd0, drop_cnt_o}, 64'd1);
        quiet(); mem_d_rd_i = 1; mem_d_accept_i = 1; mem_d_addr_i = 32'h8000_1010; tick();
        quiet(); mem_d_ack_i = 1; mem_d_data_rd_i = 32'hDEAD_BEEF; mem_d_addr_i = 32'h0; tick();
        chk("t4_count", {59'd0, count_o}, 64'd2);
        trig_pc_i = 32'h8000_0500;
        fetch(32'h8000_0500);
        for (int k = 0; k < 7; k++) fetch(32'h8000_0600 + 32'(k * 4));
        chk("t4_state", {62'd0, state_o}, 64'd3);
        drain();

`ifdef TRACE_FILTER_EN
        filt_base_i = 32'h8000_1000; filt_mask_i = 32'hFFFF_F000;
        trig_pc_i = 32'hFFFF_FFF0;
        pulse_arm();
        quiet(); mem_d_wr_i = 4'h3; mem_d_accept_i = 1; mem_d_addr_i = 32'h8000_1004; tick();
        quiet(); mem_d_wr_i = 4'h3; mem_d_accept_i = 1; mem_d_addr_i = 32'h8000_2000; tick();
        chk("t6_count", {59'd0, count_o}, 64'd1);
        chk("t6_drop", {48'd0, drop_cnt_o}, 64'd0);
        chk("t6_addr", {32'd0, mem_d_addr_i}, 64'h8000_2000);
        pulse_clear();
`endif

        // Randomized traffic
        trig_pc_i = 32'h8000_0020;
        for (int c = 0; c < 4000; c++) begin
            quiet();
            arm_i   = ($urandom_range(0, 29) == 0);
            clear_i = ($urandom_range(0, 299) == 0);
            if (arm_i) begin
                trig_en_i   = $urandom_range(0, 1);
                mode_wrap_i = $urandom_range(0, 1);
            end
            mem_i_valid_i   = ($urandom_range(0, 2) == 0);
            mem_i_pc_i      = 32'h8000_0000 + 32'($urandom_range(0, 31) * 4);
            mem_i_inst_i    = {$urandom, $urandom};
            mem_d_addr_i    = (($urandom_range(0, 1) == 0) ? 32'h8000_1000 : 32'h8000_2000)
                              + 32'($urandom_range(0, 255) * 4);
            mem_d_wr_i      = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            mem_d_rd_i      = ($urandom_range(0, 2) == 0);
            mem_d_accept_i  = ($urandom_range(0, 3) != 0);
            mem_d_ack_i     = ($urandom_range(0, 2) == 0);
            mem_d_data_wr_i = $urandom;
            mem_d_data_rd_i = $urandom;
            tr_ready_i      = $urandom_range(0, 1);
            tick();
            if (c % 1000 == 999) async_reset();
        end
        quiet(); tr_ready_i = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
